// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared types and constants for the 8N1 UART receiver.
//   - rx_state_t : receiver FSM states
//   - BAUD_*     : supported baud rates, indexed by the 2-bit baud select
//   - DIV_W      : width of the baud-tick divisor
//   - div_for()  : rounded tick divisor, round(clk_freq / (baud * oversample))
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned BAUD_4800   = 4_800;
    localparam int unsigned BAUD_9600   = 9_600;
    localparam int unsigned BAUD_19200  = 19_200;
    localparam int unsigned BAUD_115200 = 115_200;

    // Wide enough for 4800 baud at clocks well beyond 100 MHz.
    localparam int DIV_W = 16;

    // Rounded divisor; adding half the denominator turns truncation into
    // round-to-nearest (100 MHz gives 1302/651/326/54).
    function automatic logic [DIV_W-1:0] div_for(input logic [1:0]  s,
                                                 input int unsigned clk_freq,
                                                 input int unsigned oversample = 16);
        int unsigned baud;
        int unsigned den;
        case (s)
            2'b00:   baud = BAUD_4800;
            2'b01:   baud = BAUD_9600;
            2'b10:   baud = BAUD_19200;
            default: baud = BAUD_115200;
        endcase
        den = baud * oversample;
        return DIV_W'((clk_freq + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Divisor counter producing a one-cycle tick every `divisor` clock cycles.
//   A restart pulse zeroes the count so the next tick lands exactly `divisor`
//   cycles later, which aligns the oversampling grid to a detected start edge.
// Ports
//   clk_in   in   1      system clock, rising edge
//   reset    in   1      asynchronous, active-low reset
//   restart  in   1      synchronous restart of the count (suppresses tick)
//   divisor  in   DIV_W  cycles per tick (0 is treated as 1)
//   tick     out  1      one-cycle tick strobe
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_rx_pkg::*;
(
    input  logic             clk_in,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;

    assign last = (divisor == '0) ? '0 : divisor - DIV_W'(1);

    // >= rather than == so a shrinking divisor can never strand the counter
    // above its terminal value.
    assign tick = !restart && (count >= last);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart || count >= last) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 asynchronous serial receiver. The RX line is synchronized, the start
//   edge aligns a 16x oversampling grid, each bit is sampled at its centre and
//   shifted in LSB first. A completed frame loads `register` and pulses `a`.
//
// Configuration macro
//   UART_RX_FRAME_ERR_EN  defined   : a frame whose stop bit is 0 is discarded
//                         undefined : the stop bit is ignored, byte delivered
//
// Parameters
//   CLK_FREQ    clk_in frequency in Hz (default 100 MHz)
//   OVERSAMPLE  baud ticks per bit period (default 16, power of two)
//
// Ports
//   clk_in     in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-low reset
//   S          in   2  baud select: 00=4800, 01=9600, 10=19200, 11=115200
//   serial_in  in   1  RX line, idle high, asynchronous to clk_in
//   register   out  8  last received byte
//   a          out  1  byte-valid strobe, one clk_in cycle
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
)
(
    input  logic       clk_in,
    input  logic       reset,
    input  logic [1:0] S,
    input  logic       serial_in,
    output logic [7:0] register,
    output logic       a
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    localparam logic [DIV_W-1:0] DIV_00 = div_for(2'b00, CLK_FREQ, OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_01 = div_for(2'b01, CLK_FREQ, OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_10 = div_for(2'b10, CLK_FREQ, OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_11 = div_for(2'b11, CLK_FREQ, OVERSAMPLE);

`ifdef UART_RX_FRAME_ERR_EN
    localparam bit DROP_BAD_STOP = 1'b1;
`else
    localparam bit DROP_BAD_STOP = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic             rx_meta;
    logic             rx_sync;
    logic             armed;
    logic [1:0]       s_lat;
    logic [DIV_W-1:0] divisor;
    logic             tick;

    rx_state_t        state;
    rx_state_t        state_next;

    logic [TW-1:0]    tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    logic             restart;
    logic             tick_clr;
    logic             shift_en;
    logic             frame_done;
    logic             load_ok;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (mark) level so a reset
    // never looks like a start bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Baud tick generation. The divisor follows the latched select, so a
    // change of S mid-frame cannot disturb the frame in flight; the counter
    // free-runs in IDLE and is realigned by `restart` at start detect.
    // ------------------------------------------------------------------
    always_comb begin
        case (s_lat)
            2'b00:   divisor = DIV_00;
            2'b01:   divisor = DIV_01;
            2'b10:   divisor = DIV_10;
            default: divisor = DIV_11;
        endcase
    end

    uart_baud_tick u_baud_tick (
        .clk_in  (clk_in),
        .reset   (reset),
        .restart (restart),
        .divisor (divisor),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        tick_clr   = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_sync && armed) begin
                    state_next = START;
                    restart    = 1'b1;
                end
            end
            START: begin
                // Mid start bit: a line back at 1 was only a glitch.
                if (tick && tick_cnt == HALF_TICK) begin
                    tick_clr   = 1'b1;
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tick_cnt == LAST_TICK) begin
                    tick_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && tick_cnt == LAST_TICK) begin
                    tick_clr   = 1'b1;
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_ok = frame_done && (rx_sync || !DROP_BAD_STOP);

    // ------------------------------------------------------------------
    // Datapath: baud select latch, tick/bit counters, shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s_lat    <= 2'b00;
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
        end else begin
            if (restart) begin
                s_lat <= S;
            end

            if (restart || tick_clr) begin
                tick_cnt <= '0;
            end else if (tick && state != IDLE) begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            if (restart) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // LSB arrives first, so shift right and insert at the MSB.
            if (shift_en) begin
                shift <= {rx_sync, shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Start re-arm. After a frame whose stop sample was 0 (e.g. a break)
    // the line must return to 1 before another start is accepted; a stop
    // sample of 1 leaves the receiver armed for an immediate next start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            armed <= 1'b1;
        end else if (rx_sync) begin
            armed <= 1'b1;
        end else if (frame_done) begin
            armed <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output register and byte-valid strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            register <= 8'h00;
            a        <= 1'b0;
        end else begin
            a <= load_ok;
            if (load_ok) begin
                register <= shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Directed stimulus with a byte scoreboard. The DUT runs at a 4 MHz nominal
//   CLK_FREQ so frames stay short; bit periods in clocks are the rounded
//   divisor times 16: 4800 -> 52*16=832, 9600 -> 26*16=416,
//   19200 -> 13*16=208, 115200 -> 2*16=32.
// -----------------------------------------------------------------------------
module tb_uart_receiver;
    import uart_rx_pkg::*;

    localparam int unsigned TB_CLK_FREQ = 4_000_000;
    localparam int          MAX_CYCLES  = 80_000;

    logic       clk_in    = 1'b0;
    logic       reset     = 1'b0;
    logic [1:0] S         = 2'b01;
    logic       serial_in = 1'b1;
    logic [7:0] register;
    logic       a;

    uart_receiver #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .OVERSAMPLE (16)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .S         (S),
        .serial_in (serial_in),
        .register  (register),
        .a         (a)
    );

    always #5 clk_in = ~clk_in;

    int         n_compared = 0;
    int         n_failed   = 0;
    int         n_pulses   = 0;
    int         n_expected = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_reg    = 8'h00;
    logic       a_prev     = 1'b0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int bit_cyc(input logic [1:0] s);
        case (s)
            2'b00:   return 832;
            2'b01:   return 416;
            2'b10:   return 208;
            default: return 32;
        endcase
    endfunction

    task automatic expect_byte(input logic [7:0] b);
        sb.push_back(b);
        exp_reg = b;
        n_expected++;
    endtask

    // Holds the line at v for cyc clocks; always returns 1 time unit after
    // a rising edge so inputs never change on the sampling edge.
    task automatic drive_bit(input logic v, input int cyc);
        serial_in = v;
        repeat (cyc) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int cyc);
        drive_bit(1'b0, cyc);
        for (int i = 0; i < 8; i++) drive_bit(data[i], cyc);
        drive_bit(stop_bit, cyc);
    endtask

    // Monitor: every strobe pops one expected byte and compares it.
    always @(negedge clk_in) begin
        if (reset) begin
            if (a) begin
                n_pulses++;
                check("a_one_cycle", {31'd0, a_prev}, 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_a", {24'd0, register}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_byte", {24'd0, register}, {24'd0, sb.pop_front()});
                end
            end
            a_prev = a;
        end else begin
            a_prev = 1'b0;
        end
    end

    initial begin
        repeat (MAX_CYCLES) @(posedge clk_in);
        $display("FAIL watchdog: run exceeded %0d cycles, expected completion", MAX_CYCLES);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset for 100 ns.
        repeat (10) @(posedge clk_in);
        #1;
        check("rst_register", {24'd0, register}, 32'h00);
        check("rst_a", {31'd0, a}, 32'd0);
        check("div_4800",   {16'd0, div_for(2'b00, 100_000_000)}, 32'd1302);
        check("div_9600",   {16'd0, div_for(2'b01, 100_000_000)}, 32'd651);
        check("div_19200",  {16'd0, div_for(2'b10, 100_000_000)}, 32'd326);
        check("div_115200", {16'd0, div_for(2'b11, 100_000_000)}, 32'd54);
        reset = 1'b1;
        drive_bit(1'b1, 2 * bit_cyc(2'b01));

        // 1. 9600 baud, 0x50.
        S = 2'b01;
        expect_byte(8'h50);
        send_frame(8'h50, 1'b1, bit_cyc(S));
        drive_bit(1'b1, 2 * bit_cyc(S));
        check("hold_t1", {24'd0, register}, {24'd0, exp_reg});

        // 2. 115200 baud, back-to-back 0xA5 then 0x3C.
        S = 2'b11;
        drive_bit(1'b1, 64);
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1, bit_cyc(S));
        expect_byte(8'h3C);
        send_frame(8'h3C, 1'b1, bit_cyc(S));
        drive_bit(1'b1, 2 * bit_cyc(S));
        check("hold_t2", {24'd0, register}, {24'd0, exp_reg});

        // 3. 9600 baud, 20 us (80 clocks) low glitch: rejected.
        S = 2'b01;
        drive_bit(1'b1, 64);
        drive_bit(1'b0, 80);
        drive_bit(1'b1, 2 * bit_cyc(S));
        check("glitch_reg", {24'd0, register}, {24'd0, exp_reg});

        // 4. 19200 baud, 0xFF with stop bit 0.
        S = 2'b10;
        drive_bit(1'b1, 64);
`ifndef UART_RX_FRAME_ERR_EN
        expect_byte(8'hFF);
`endif
        send_frame(8'hFF, 1'b0, bit_cyc(S));
        drive_bit(1'b1, 2 * bit_cyc(S));
        check("ferr_reg", {24'd0, register}, {24'd0, exp_reg});

        // Break: line low for 25 bit periods yields one zero-stop frame only.
        S = 2'b11;
        drive_bit(1'b1, 64);
`ifndef UART_RX_FRAME_ERR_EN
        expect_byte(8'h00);
`endif
        drive_bit(1'b0, 25 * bit_cyc(S));
        drive_bit(1'b1, 2 * bit_cyc(S));
        check("break_reg", {24'd0, register}, {24'd0, exp_reg});
        expect_byte(8'h96);
        send_frame(8'h96, 1'b1, bit_cyc(S));
        drive_bit(1'b1, 2 * bit_cyc(S));
        check("post_break_reg", {24'd0, register}, {24'd0, exp_reg});

        // 5. 19200 baud, reset during data bit 4 of 0x81, then 0x7E.
        S = 2'b10;
        drive_bit(1'b1, 64);
        drive_bit(1'b0, bit_cyc(S));
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i), bit_cyc(S));
        drive_bit(1'b0, 100);
        reset = 1'b0;
        exp_reg = 8'h00;
        drive_bit(1'b0, 20);
        check("abort_register", {24'd0, register}, 32'h00);
        check("abort_a", {31'd0, a}, 32'd0);
        serial_in = 1'b1;
        drive_bit(1'b1, 4);
        reset = 1'b1;
        drive_bit(1'b1, 2 * bit_cyc(S));
        check("post_abort_reg", {24'd0, register}, 32'h00);
        expect_byte(8'h7E);
        send_frame(8'h7E, 1'b1, bit_cyc(S));
        drive_bit(1'b1, 2 * bit_cyc(S));

        // 6. 0x55 at 9600 with S switched to 11 during bit 3; next byte at 115200.
        S = 2'b01;
        drive_bit(1'b1, 64);
        expect_byte(8'h55);
        drive_bit(1'b0, bit_cyc(2'b01));
        for (int i = 0; i < 8; i++) begin
            if (i == 3) S = 2'b11;
            drive_bit(1'(8'h55 >> i), bit_cyc(2'b01));
        end
        drive_bit(1'b1, bit_cyc(2'b01));
        drive_bit(1'b1, 2 * bit_cyc(2'b11));
        expect_byte(8'hC3);
        send_frame(8'hC3, 1'b1, bit_cyc(2'b11));
        drive_bit(1'b1, 2 * bit_cyc(2'b11));
        check("hold_t6", {24'd0, register}, {24'd0, exp_reg});

        drive_bit(1'b1, 200);
        check("sb_empty", sb.size(), 32'd0);
        check("pulse_count", n_pulses, n_expected);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
